// File: rtl/fsm_evt_stretch_pkg.sv
// Shared definitions for the event stretcher: state encoding, the default
// stretch length derived from the divided FSM clock, and counter sizing.
package fsm_evt_stretch_pkg;

  localparam int FSM_CLK_ARR    = 125000;
  localparam int FSM_CLK_PERIOD = 2 * (FSM_CLK_ARR + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    GAP  = 2'b10
  } state_t;

  // Width of a counter that must reach max(hold_cyc, gap_cyc)-1; never below 1 bit.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    int m;
    m = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fsm_evt_stretch_chan.sv
// One stretcher channel: edge detect, HOLD/GAP sequencer, pending queue
// counter with saturation and a sticky overflow flag.
module fsm_evt_chan
  import fsm_evt_stretch_pkg::*;
#(
  parameter int HOLD_CYC = FSM_CLK_PERIOD,
  parameter int GAP_CYC  = FSM_CLK_PERIOD,
  parameter int PEND_W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic evt_in,
  input  logic ovf_clr,
  output logic evt_hold,
  output logic busy,
  output logic ovf
);

  localparam int                CW        = cnt_width(HOLD_CYC, GAP_CYC);
  localparam logic [CW-1:0]     HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [PEND_W-1:0]   pend_reg, pend_next;
  logic                prev_reg;
  logic                armed_reg;
  logic                ovf_reg, ovf_next;
  logic                evt_hold_reg, evt_hold_next;
  logic                busy_reg, busy_next;
  logic                rise;
  logic                pend_inc;
  logic                ovf_set;

  // A level already high when reset releases must be seen low before it can count.
  assign rise = evt_in & ~prev_reg & armed_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pend_reg     <= '0;
      prev_reg     <= 1'b0;
      armed_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      evt_hold_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      pend_reg     <= pend_next;
      prev_reg     <= evt_in;
      armed_reg    <= armed_reg | ~evt_in;
      ovf_reg      <= ovf_next;
      evt_hold_reg <= evt_hold_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pend_next  = pend_reg;
    pend_inc   = 1'b0;
    ovf_set    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        pend_inc = rise;
        if (cnt_reg == HOLD_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next = '0;
          // A rise on the final gap cycle replaces the dequeued entry, or starts directly.
          if (pend_reg != '0) begin
            state_next = HOLD;
            if (!rise) pend_next = pend_reg - PEND_W'(1);
          end else if (rise) begin
            state_next = HOLD;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
          pend_inc = rise;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    if (pend_inc) begin
      if (pend_reg == PEND_MAX) ovf_set = 1'b1;
      else                      pend_next = pend_reg + PEND_W'(1);
    end
  end

  always_comb begin
    evt_hold_next = (state_next == HOLD);
    busy_next     = (state_next != IDLE) || (pend_next != '0);
    ovf_next      = ovf_set | (ovf_reg & ~ovf_clr);
  end

  assign evt_hold = evt_hold_reg;
  assign busy     = busy_reg;
  assign ovf      = ovf_reg;

endmodule

// File: rtl/fsm_evt_stretch.sv
// Multi-channel event stretcher: widens short clk-domain events so the slow
// divided FSM clock samples each as exactly one high-then-low window.
module fsm_evt_stretch
  import fsm_evt_stretch_pkg::*;
#(
  parameter int CH       = 4,
  parameter int HOLD_CYC = FSM_CLK_PERIOD,
  parameter int GAP_CYC  = FSM_CLK_PERIOD,
  parameter int PEND_W   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] evt_in,
  input  logic [CH-1:0] ovf_clr,
  output logic [CH-1:0] evt_hold,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] ovf
);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_chan
      fsm_evt_chan #(
        .HOLD_CYC (HOLD_CYC),
        .GAP_CYC  (GAP_CYC),
        .PEND_W   (PEND_W)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt_in   (evt_in[gi]),
        .ovf_clr  (ovf_clr[gi]),
        .evt_hold (evt_hold[gi]),
        .busy     (busy[gi]),
        .ovf      (ovf[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_fsm_evt_stretch.sv
// Directed bench for fsm_evt_stretch with short HOLD/GAP; each run records
// per-cycle outputs into bit vectors compared against hand-derived windows.
module tb_fsm_evt_stretch;

  logic       clk;
  logic       rst_n;
  logic [1:0] evt_in;
  logic [1:0] ovf_clr;
  logic [1:0] evt_hold;
  logic [1:0] busy;
  logic [1:0] ovf;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] h0, h1, b0, b1, o0;

  fsm_evt_stretch #(
    .CH       (2),
    .HOLD_CYC (4),
    .GAP_CYC  (3),
    .PEND_W   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .evt_in   (evt_in),
    .ovf_clr  (ovf_clr),
    .evt_hold (evt_hold),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Bit i of each stimulus vector is applied before clock edge i; bit i of
  // each capture vector is the output registered by that edge.
  task automatic run_vec(input logic [63:0] s0, input logic [63:0] s1,
                         input logic [63:0] c0, input logic [63:0] rl, input int n);
    h0 = '0; h1 = '0; b0 = '0; b1 = '0; o0 = '0;
    for (int i = 0; i < n; i++) begin
      evt_in  = {s1[i], s0[i]};
      ovf_clr = {1'b0, c0[i]};
      rst_n   = ~rl[i];
      @(posedge clk);
      #1;
      h0[i] = evt_hold[0];
      h1[i] = evt_hold[1];
      b0[i] = busy[0];
      b1[i] = busy[1];
      o0[i] = ovf[0];
    end
    evt_in  = '0;
    ovf_clr = '0;
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    evt_in  = '0;
    ovf_clr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_hold", {62'd0, evt_hold}, 64'd0);
    check_eq("reset_busy", {62'd0, busy}, 64'd0);
    check_eq("reset_ovf",  {62'd0, ovf}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single event held high 10 cycles: one 4-cycle window, busy 7 cycles.
    run_vec(64'h3FF, 64'h0, 64'h0, 64'h0, 16);
    check_eq("single_hold0", h0, rng(0, 3));
    check_eq("single_busy0", b0, rng(0, 6));
    check_eq("single_hold1", h1, 64'h0);
    check_eq("single_busy1", b1, 64'h0);

    // Rises at t and t+2: second event queued and replayed after the gap.
    run_vec(64'h5, 64'h0, 64'h0, 64'h0, 18);
    check_eq("b2b_hold0", h0, rng(0, 3) | rng(7, 10));
    check_eq("b2b_busy0", b0, rng(0, 13));

    // Six rises: three queue to saturation, one dequeues at edge 7, the
    // rise at 8 refills and the rise at 10 is dropped.
    run_vec(64'h555, 64'h0, 64'h0, 64'h0, 40);
    check_eq("flood_hold0", h0, rng(0, 3) | rng(7, 10) | rng(14, 17) | rng(21, 24) | rng(28, 31));
    check_eq("flood_busy0", b0, rng(0, 34));
    check_eq("flood_ovf0",  o0, rng(10, 39));

    run_vec(64'h0, 64'h0, 64'h1, 64'h0, 2);
    check_eq("ovf_clear", o0, 64'h0);

    // Clear coincident with the drop loses; a later clear takes effect.
    run_vec(64'h555, 64'h0, 64'h1400, 64'h0, 40);
    check_eq("clr_vs_set_ovf0", o0, rng(10, 11));
    check_eq("clr_vs_set_hold0", h0, rng(0, 3) | rng(7, 10) | rng(14, 17) | rng(21, 24) | rng(28, 31));

    // Rise on the last gap cycle with nothing pending restarts HOLD directly.
    run_vec(64'h81, 64'h0, 64'h0, 64'h0, 18);
    check_eq("lastgap_hold0", h0, rng(0, 3) | rng(7, 10));
    check_eq("lastgap_busy0", b0, rng(0, 13));
    check_eq("lastgap_ovf0",  o0, 64'h0);

    // Simultaneous rises on both channels are handled independently.
    run_vec(64'h1, 64'h5, 64'h0, 64'h0, 18);
    check_eq("multi_hold0", h0, rng(0, 3));
    check_eq("multi_hold1", h1, rng(0, 3) | rng(7, 10));
    check_eq("multi_busy1", b1, rng(0, 13));

    // Reset at edge 2 aborts HOLD; the still-high level is ignored until it
    // drops at edge 8 and rises again at edge 9.
    run_vec(64'h7EFF, 64'h0, 64'h0, 64'h4, 20);
    check_eq("rst_hold0", h0, rng(0, 1) | rng(9, 12));
    check_eq("rst_busy0", b0, rng(0, 1) | rng(9, 15));
    check_eq("rst_ovf0",  o0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
